// File: rtl/dmem_if.sv
// dmem_if
//   Load/store bus between the MEM stage (master) and the data-memory
//   responder (slave).
//   Signals:
//     req_valid  master->slave  request present
//     req_ready  slave->master  responder can accept
//     req_we     master->slave  1 = store, 0 = load
//     req_addr   master->slave  byte address, ADDR_W bits
//     req_wdata  master->slave  store data
//     resp_valid slave->master  one-cycle response strobe
//     resp_rdata slave->master  load data, 0 outside a load response
//     resp_err   slave->master  misalignment flag, qualified by resp_valid
//     stall      slave->master  pipeline hold request
interface dmem_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              stall;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, stall
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder
//   Target end of the MEM-stage load/store bus. Accepts one word request
//   at a time, waits LATENCY cycles, then returns a one-cycle response
//   (load data or a store acknowledge). stall holds the pipeline while a
//   request is pending or in flight.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous reset, active-high
//     bus  dmem_if.slave (request/response handshake and stall)
//   Parameters:
//     DEPTH    number of 32-bit words, power of two
//     ADDR_W   byte-address width, must match the interface
//     LATENCY  WAIT cycles from accept to response, >= 1
//   Optional feature:
//     DMEM_MISALIGN_ERR_EN  when defined, requests with req_addr[1:0] != 0
//     complete with resp_err=1, no store and zero read data. When
//     undefined, the low address bits are ignored and resp_err is 0.
//   The array powers up with mem[i] = i and is not cleared by reset.
module dmem_responder #(
  parameter int DEPTH   = 128,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic  clk,
  input  logic  rst,
  dmem_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  function automatic logic [DEPTH-1:0][31:0] init_mem();
    logic [DEPTH-1:0][31:0] v;
    for (int i = 0; i < DEPTH; i++) begin
      v[i] = 32'(i);
    end
    return v;
  endfunction

  // Power-up contents come from the declaration; reset never touches them.
  logic [DEPTH-1:0][31:0] r_mem = init_mem();

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_we;
  logic [IDX_W-1:0]   r_idx;
  logic [31:0]        r_wdata;
  logic               r_req_ready;
  logic               r_resp_valid;
  logic [31:0]        r_resp_rdata;
  logic               r_resp_err;

  logic               w_access;
  logic               w_mem_we;
  logic               w_unused_addr;
  logic               w_bad_align;

`ifdef DMEM_MISALIGN_ERR_EN
  logic               r_mis;
  assign w_bad_align = r_mis;
`else
  assign w_bad_align = 1'b0;
`endif

  // Bits outside the word index are deliberately ignored (address wrap).
  assign w_unused_addr = ^{bus.req_addr[ADDR_W-1:IDX_W+2], bus.req_addr[1:0]};

  // Access edge: last WAIT cycle. An asynchronous reset forces IDLE
  // immediately, so a pending store can never commit afterwards.
  assign w_access = (r_state == S_WAIT) && (r_cnt == CNT_W'(1));
  assign w_mem_we = w_access && r_we && !w_bad_align;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_idx        <= '0;
      r_wdata      <= '0;
`ifdef DMEM_MISALIGN_ERR_EN
      r_mis        <= 1'b0;
`endif
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_we        <= bus.req_we;
            r_idx       <= bus.req_addr[IDX_W+1:2];
            r_wdata     <= bus.req_wdata;
`ifdef DMEM_MISALIGN_ERR_EN
            r_mis       <= |bus.req_addr[1:0];
`endif
            r_cnt       <= CNT_W'(LATENCY);
            r_req_ready <= 1'b0;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_access) begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= w_bad_align;
            // Stores acknowledge with zero data; misaligned loads return zero.
            r_resp_rdata <= (r_we || w_bad_align) ? 32'd0 : r_mem[r_idx];
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          r_resp_valid <= 1'b0;
          r_resp_rdata <= '0;
          r_resp_err   <= 1'b0;
          r_req_ready  <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;
  // Low in RESP so the pipeline advances together with the data.
  assign bus.stall      = ((r_state == S_IDLE) && bus.req_valid) || (r_state == S_WAIT);

endmodule
